// File: rtl/aer_event_encoder.sv
// AER event encoder: timestamps accepted spikes and queues them with
// timestep-boundary marker words in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   spike_in, addr_in spike request and neuron address from the handler
//   ack_out           combinational accept back to the handler
//   tick              one-cycle timestep strobe
//   ev_valid/ev_ready/ev_data  output event stream (valid/ready)
//   level             FIFO occupancy
//   ts_now            current timestep
//   marker_lost       sticky: a marker had to be discarded
module aer_event_encoder #(
    parameter int ADDR_W = 4,
    parameter int TS_W   = 8,
    parameter int DEPTH  = 4,
    localparam int W     = 1 + TS_W + ADDR_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spike_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              ack_out,
    input  logic              tick,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [W-1:0]      ev_data,
    output logic [LW-1:0]     level,
    output logic [TS_W-1:0]   ts_now,
    output logic              marker_lost
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]      mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              mk_pend_q, mk_pend_d;
    logic [TS_W-1:0]   mk_ts_q, mk_ts_d;
    logic              lost_q, lost_d;

    logic              full;
    logic              pop;
    logic              push;
    logic [W-1:0]      wdata;

    always_comb begin
        full    = (level_q == LW'(DEPTH));
        pop     = (level_q != '0) & ev_ready;
        ack_out = spike_in & ~full & ~mk_pend_q & ~tick & ~rst;

        push      = 1'b0;
        wdata     = {1'b0, ts_q, addr_in};
        mk_pend_d = mk_pend_q;
        mk_ts_d   = mk_ts_q;
        lost_d    = lost_q;
        ts_d      = tick ? ts_q + TS_W'(1) : ts_q;

        if (mk_pend_q) begin
            if (!full) begin
                push  = 1'b1;
                wdata = {1'b1, mk_ts_q, {ADDR_W{1'b0}}};
                // A tick in the same cycle queues behind the marker
                // that is leaving now, so nothing is lost.
                mk_pend_d = tick;
                if (tick) begin
                    mk_ts_d = ts_q;
                end
            end else if (tick) begin
                lost_d = 1'b1;
            end
        end else if (tick) begin
            if (!full) begin
                push  = 1'b1;
                wdata = {1'b1, ts_q, {ADDR_W{1'b0}}};
            end else begin
                mk_pend_d = 1'b1;
                mk_ts_d   = ts_q;
            end
        end else if (ack_out) begin
            push = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ts_q      <= '0;
            mk_pend_q <= 1'b0;
            mk_ts_q   <= '0;
            lost_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ts_q      <= ts_d;
            mk_pend_q <= mk_pend_d;
            mk_ts_q   <= mk_ts_d;
            lost_q    <= lost_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign ev_valid    = (level_q != '0);
    assign ev_data     = mem[rd_ptr_q];
    assign level       = level_q;
    assign ts_now      = ts_q;
    assign marker_lost = lost_q;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Self-checking bench for aer_event_encoder: directed table, corner
// sequences and randomized traffic against a queue-based reference.
module tb_aer_event_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spike_in;
    logic [3:0]  addr_in;
    logic        ack_out;
    logic        tick;
    logic        ev_valid;
    logic        ev_ready;
    logic [12:0] ev_data;
    logic [2:0]  level;
    logic [7:0]  ts_now;
    logic        marker_lost;

    aer_event_encoder #(.ADDR_W(4), .TS_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .addr_in(addr_in),
        .ack_out(ack_out), .tick(tick), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_data(ev_data), .level(level),
        .ts_now(ts_now), .marker_lost(marker_lost)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: event queue plus step bookkeeping
    logic [12:0] mq[$];
    logic [7:0]  m_ts;
    bit          m_pend;
    logic [7:0]  m_pts;
    bit          m_lost;

    // values seen during the most recent cycle
    logic        s_ack, s_valid, s_lost;
    logic [12:0] s_data;
    logic [2:0]  s_level;
    logic [7:0]  s_ts;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts   = 8'h00;
        m_pend = 1'b0;
        m_pts  = 8'h00;
        m_lost = 1'b0;
    endtask

    task automatic cyc(input logic s, input logic [3:0] a, input logic t,
                       input logic r, input logic rs);
        bit full;
        bit e_ack;
        bit have_w;
        logic [12:0] w;
        spike_in = s;
        addr_in  = a;
        tick     = t;
        ev_ready = r;
        rst      = rs;
        @(negedge clk);
        full  = (mq.size() == 4);
        e_ack = s && !full && !m_pend && !t && !rs;
        s_ack = ack_out; s_valid = ev_valid; s_data = ev_data;
        s_level = level; s_ts = ts_now; s_lost = marker_lost;
        chk("m_ack", ack_out, e_ack);
        chk("m_valid", ev_valid, mq.size() != 0);
        chk("m_level", level, mq.size());
        chk("m_ts", ts_now, m_ts);
        chk("m_lost", marker_lost, m_lost);
        if (mq.size() != 0) chk("m_data", ev_data, mq[0]);
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            have_w = 0;
            w = '0;
            if (m_pend) begin
                if (!full) begin
                    have_w = 1; w = {1'b1, m_pts, 4'h0};
                    if (t) m_pts = m_ts;
                    else m_pend = 0;
                end else if (t) begin
                    m_lost = 1;
                end
            end else if (t) begin
                if (!full) begin
                    have_w = 1; w = {1'b1, m_ts, 4'h0};
                end else begin
                    m_pend = 1; m_pts = m_ts;
                end
            end else if (e_ack) begin
                have_w = 1; w = {1'b0, m_ts, a};
            end
            if (mq.size() != 0 && r) void'(mq.pop_front());
            if (have_w) mq.push_back(w);
            if (t) m_ts = m_ts + 8'd1;
        end
        #1;
    endtask

    typedef struct {
        logic s; logic [3:0] a; logic t; logic r; logic rs;
        logic e_ack; logic e_val; logic [12:0] e_data;
        logic [2:0] e_lvl; logic [7:0] e_ts;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic s, logic [3:0] a, logic t, logic r,
                                logic rs, logic ea, logic ev,
                                logic [12:0] ed, logic [2:0] el,
                                logic [7:0] et);
        vec_t v;
        v.s = s; v.a = a; v.t = t; v.r = r; v.rs = rs;
        v.e_ack = ea; v.e_val = ev; v.e_data = ed;
        v.e_lvl = el; v.e_ts = et;
        return v;
    endfunction

    initial begin
        // single spike, then ticks up to ts=7, then tick+spike collision
        tbl[0] = mk(1, 5, 0, 1, 1, 0, 0, 13'h0000, 0, 8'd0);
        tbl[1] = mk(1, 5, 0, 1, 0, 1, 0, 13'h0000, 0, 8'd0);
        tbl[2] = mk(0, 0, 0, 1, 0, 0, 1, 13'h0005, 1, 8'd0);
        tbl[3] = mk(0, 0, 0, 1, 0, 0, 0, 13'h0000, 0, 8'd0);
        for (int k = 4; k <= 10; k++) begin
            tbl[k] = mk(0, 0, 1, 1, 0, 0, k >= 5,
                        13'h1000 + 13'((k - 5) * 16), (k >= 5) ? 3'd1 : 3'd0,
                        8'(k - 4));
        end
        tbl[11] = mk(1, 9, 1, 1, 0, 0, 1, 13'h1060, 1, 8'd7);
        tbl[12] = mk(1, 9, 0, 1, 0, 1, 1, 13'h1070, 1, 8'd8);
        tbl[13] = mk(0, 0, 0, 1, 0, 0, 1, 13'h0089, 1, 8'd8);
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 0, 13'h0000, 0, 8'd8);

        rst = 1; spike_in = 0; addr_in = 0; tick = 0; ev_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].t, tbl[i].r, tbl[i].rs);
            chk($sformatf("t%0d_ack", i), s_ack, tbl[i].e_ack);
            chk($sformatf("t%0d_val", i), s_valid, tbl[i].e_val);
            chk($sformatf("t%0d_lvl", i), s_level, tbl[i].e_lvl);
            chk($sformatf("t%0d_ts", i), s_ts, tbl[i].e_ts);
            if (tbl[i].e_val) chk($sformatf("t%0d_data", i), s_data, tbl[i].e_data);
        end

        // backpressure: only four spikes fit
        for (int i = 0; i < 6; i++) begin
            cyc(1, 3, 0, 0, 0);
            chk($sformatf("bp_ack%0d", i), s_ack, i < 4);
        end
        cyc(0, 0, 0, 1, 0);
        chk("bp_full", s_level, 3'd4);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk($sformatf("bp_word%0d", i), s_data, {1'b0, 8'd8, 4'd3});
        end
        cyc(0, 0, 0, 1, 0);
        chk("bp_empty", s_level, 3'd0);

        // tick while full, then a second tick while the marker waits
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
        cyc(1, 7, 1, 0, 0);
        chk("ft_ack_tick", s_ack, 1'b0);
        cyc(1, 7, 1, 0, 0);
        chk("ft_ack_pend", s_ack, 1'b0);
        cyc(1, 7, 0, 0, 0);
        chk("ft_lost", s_lost, 1'b1);
        chk("ft_ts", s_ts, 8'd10);
        cyc(1, 7, 0, 1, 0);
        chk("ft_ack_full", s_ack, 1'b0);
        cyc(1, 7, 0, 0, 0);
        chk("ft_lvl3", s_level, 3'd3);
        chk("ft_ack_mk", s_ack, 1'b0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("ft_marker", s_data, 13'h1080);
        cyc(0, 0, 0, 1, 0);

        // reset with level=3 and a pending marker
        for (int i = 0; i < 4; i++) cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 2, 0, 0, 1);
        chk("rs_pre_lvl", s_level, 3'd3);
        chk("rs_ack", s_ack, 1'b0);
        cyc(1, 6, 0, 0, 0);
        chk("rs_lvl", s_level, 3'd0);
        chk("rs_val", s_valid, 1'b0);
        chk("rs_ts", s_ts, 8'd0);
        chk("rs_lost", s_lost, 1'b0);
        chk("rs_ack_after", s_ack, 1'b1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // timestep wrap
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("wrap_ts", s_ts, 8'd0);
        chk("wrap_marker", s_data, 13'h1FF0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1, 4'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
